stencil_linebuf_ub: RTL and testbench
=====================================

Name: stencil_linebuf_ub

Overview:
- Streaming, parametrised successor to the per-buffer unified-buffer RAMs (e.g. the 64x64 input buffer feeding the 3x3 blur).
- Accepts one pixel per cycle in raster order over a valid/ready handshake.
- Holds SH-1 line delays plus an SH x SW window register, generating read addresses internally from its own column/row counters instead of external ctrl_vars.
- Emits the full SH x SW stencil for every in-bounds window position, with backpressure and frame/flush control.

Parameters:
- DATA_W, 16, pixel width in bits
- IMG_W, 64, image columns (>= SW)
- IMG_H, 64, image rows (>= SH)
- SW, 3, stencil width (>= 1)
- SH, 3, stencil height (>= 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous frame abort; clears counters and outputs, RAM untouched
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept pixel
- in_data  in  DATA_W  pixel, raster order, x fastest
- out_valid  out  1  stencil valid
- out_ready  in  1  consumer accepts stencil
- out_taps  out  SH*SW*DATA_W  flattened taps; tap t = r*SW+c at bits [t*DATA_W +: DATA_W]
- out_x  out  16  top-left column of window
- out_y  out  16  top-left row of window
- frame_done  out  1  one-cycle pulse coincident with the last stencil of a frame

Behaviour:
- Reset/flush values: out_valid=0, frame_done=0, out_x=0, out_y=0, out_taps=0, x=y=0. in_ready follows its equation. rst and flush are equivalent except rst also zeroes the window registers. If both are asserted, same result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no skid buffer).
  - Accept = in_valid && in_ready.
  - No state changes on cycles without accept, except out_valid clearing when out_valid && out_ready.
- Counters on accept:
  - x increments.
  - At x==IMG_W-1: x->0, y increments.
  - At (IMG_W-1, IMG_H-1): both ->0 (next frame starts without flush).
- Line delays: SH-1 arrays of IMG_W words, L0..L(SH-2). On accept at column x:
  - read old Lk[x] for all k;
  - write L0[x]=in_data and Lk[x]=old L(k-1)[x].
  - Read-before-write within the cycle.
- Window update on accept:
  - window[r][c] <= window[r][c+1] for c<SW-1.
  - New column window[SH-1][SW-1]=in_data, window[SH-1-k-1][SW-1]=old Lk[x].
- Output on accept at (x,y) with x>=SW-1 and y>=SH-1:
  - next cycle out_valid=1, out_x=x-SW+1, out_y=y-SH+1, out_taps=window (post-update).
  - tap t=r*SW+c = pixel(out_x+c, out_y+r).
  - Latency: 1 cycle from the accept of the bottom-right pixel.
- Accept that produces no output: out_valid clears (only possible when out_valid was 0 or consumed).
- Stall: while out_valid && !out_ready, out_taps, out_x, out_y are held and in_ready=0.
- frame_done=1 for exactly the cycle out_valid first asserts for window (IMG_W-SW, IMG_H-SH). It is held with the stencil under stall and clears when that stencil is consumed.
- Stale columns from the previous row after a row wrap are never emitted; the x>=SW-1 gate guarantees this.
- Outputs per frame: (IMG_W-SW+1)*(IMG_H-SH+1).
- Width rules: counters sized $clog2(IMG_W)/$clog2(IMG_H), zero-extended to 16 on out_x/out_y. No arithmetic on data.

Decomposition:
- Package stencil_ub_pkg:
  - function tap_index(r,c,SW);
  - function clog2-safe width helper;
  - default-geometry localparams.
- One sub-module, stencil_line_delay: a single IMG_W x DATA_W row delay with async read, sync write, and shared address. The top instantiates SH-1 of them in cascade.
- Counters, window and handshake stay in the top.

Test Plan:
- Ramp, default params (pixel=y*64+x), in_valid=1, out_ready=1:
  - first out_valid 1 cycle after the 131st accept;
  - taps {0,1,2,64,65,66,128,129,130}, out_x=0, out_y=0;
  - 3844 stencils total;
  - frame_done coincides with (61,61), taps ending 4095.
- Backpressure: drop out_ready for 5 cycles mid-row:
  - in_ready=0, stencil held stable;
  - on release there is no loss or duplication, and the stencil sequence is identical to the unstalled run.
- Random in_valid bubbles (50%): the output sequence, coordinates and taps match the golden model exactly.
- Flush after row 10 of frame 1, then a full ramp frame:
  - no stencil is emitted until (2,2) of the new frame;
  - taps contain only new-frame data;
  - 3844 outputs.
- Back-to-back frames with no flush:
  - frame_done pulses twice;
  - first stencil of frame 2 = {0,1,2,64,...} exactly.
- Variant SW=5, SH=5, IMG_W=16, IMG_H=8:
  - 48 stencils;
  - first taps = pixel(c,r) for r,c in 0..4;
  - the rst pulse mid-frame restarts cleanly.

Source files
------------

// File: rtl/stencil_linebuf_ub_pkg.sv
// Shared geometry defaults and index helpers for the streaming stencil line buffer.
package stencil_ub_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_SW     = 3;
  localparam int DEF_SH     = 3;
  localparam int COORD_W    = 16;

  // Flattened tap position of window row r, column c.
  function automatic int tap_index(input int r, input int c, input int sw);
    return r * sw + c;
  endfunction

  // Counter width that stays >= 1 even for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stencil_linebuf_ub_if.sv
// Pixel-in / stencil-out handshake bundle for the stencil line buffer.
interface stencil_linebuf_ub_if
  import stencil_ub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SW     = DEF_SW,
  parameter int SH     = DEF_SH
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SH*SW*DATA_W-1:0]   out_taps;
  logic [COORD_W-1:0]        out_x;
  logic [COORD_W-1:0]        out_y;
  logic                      frame_done;

  // Pixel source and stencil consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_taps, out_x, out_y, frame_done
  );

  // Line buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_taps, out_x, out_y, frame_done
  );

endinterface

// File: rtl/stencil_line_delay.sv
// One image row of delay: asynchronous read and synchronous write on a shared column address.
module stencil_line_delay
  import stencil_ub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  localparam int AW    = cnt_width(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [IMG_W];

  // Old contents are visible combinationally, so a same-cycle write is read-before-write.
  assign rd_data = mem[addr];

  // Row storage is never cleared; the window gating hides stale words.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/stencil_linebuf_ub.sv
// Streaming SH x SW stencil generator: raster pixels in, full window plus its
// top-left coordinate out, with backpressure, flush and frame-done marking.
module stencil_linebuf_ub
  import stencil_ub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int SW     = DEF_SW,
  parameter int SH     = DEF_SH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  stencil_linebuf_ub_if.slave  ub
);

  localparam int XW = cnt_width(IMG_W);
  localparam int YW = cnt_width(IMG_H);
  localparam int NL = SH - 1;
  localparam int TW = SH * SW * DATA_W;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(SW - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(SH - 1);

  logic [XW-1:0]         x_p0;
  logic [YW-1:0]         y_p0;
  logic [DATA_W-1:0]     win_p0  [SH][SW];
  logic [DATA_W-1:0]     win_nxt [SH][SW];
  logic [DATA_W-1:0]     lb_rd   [NL];
  logic [DATA_W-1:0]     lb_wr   [NL];
  logic [TW-1:0]         taps_nxt;

  logic                  vld_p1;
  logic                  fd_p1;
  logic [TW-1:0]         taps_p1;
  logic [COORD_W-1:0]    ox_p1;
  logic [COORD_W-1:0]    oy_p1;

  logic                  clr;
  logic                  acc;
  logic                  emit;
  logic                  last_pix;

  // rst and flush both abort the frame; flush leaves the window contents alone.
  assign clr         = rst | flush;
  assign ub.in_ready = !vld_p1 || ub.out_ready;
  assign acc         = ub.in_valid && ub.in_ready && !clr;
  // A window is complete once the pixel under the bottom-right tap lands; this
  // also keeps columns left over from the previous row from ever being emitted.
  assign emit        = (x_p0 >= X_FIRST) && (y_p0 >= Y_FIRST);
  assign last_pix    = (x_p0 == X_LAST) && (y_p0 == Y_LAST);

  // Cascade of row delays: L0 holds the previous row, L(k) the row k+1 above.
  for (genvar k = 0; k < NL; k++) begin : g_line
    if (k == 0) begin : g_head
      assign lb_wr[k] = ub.in_data;
    end else begin : g_tail
      assign lb_wr[k] = lb_rd[k-1];
    end

    stencil_line_delay #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W)
    ) u_line (
      .clk     (clk),
      .we      (acc),
      .addr    (x_p0),
      .wr_data (lb_wr[k]),
      .rd_data (lb_rd[k])
    );
  end

  // Next window: shift left one column and insert the new column, oldest row at top.
  always_comb begin
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        win_nxt[r][c] = win_p0[r][c];
      end
    end
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW - 1; c++) begin
        win_nxt[r][c] = win_p0[r][c+1];
      end
    end
    win_nxt[SH-1][SW-1] = ub.in_data;
    for (int k = 0; k < NL; k++) begin
      win_nxt[SH-2-k][SW-1] = lb_rd[k];
    end
  end

  // Flatten the post-update window into the tap bus layout.
  always_comb begin
    taps_nxt = '0;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        taps_nxt[tap_index(r, c, SW)*DATA_W +: DATA_W] = win_nxt[r][c];
      end
    end
  end

  // Raster position of the next pixel to arrive; wraps into the next frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (acc) begin
      if (x_p0 == X_LAST) begin
        x_p0 <= '0;
        y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + 1'b1;
      end else begin
        x_p0 <= x_p0 + 1'b1;
      end
    end
  end

  // Window shift register, advanced only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < SH; r++) begin
        for (int c = 0; c < SW; c++) begin
          win_p0[r][c] <= '0;
        end
      end
    end else if (acc) begin
      win_p0 <= win_nxt;
    end
  end

  // ---- stage p0 -> p1: registered stencil output, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1  <= 1'b0;
      fd_p1   <= 1'b0;
      taps_p1 <= '0;
      ox_p1   <= '0;
      oy_p1   <= '0;
    end else if (acc) begin
      vld_p1 <= emit;
      fd_p1  <= emit && last_pix;
      if (emit) begin
        taps_p1 <= taps_nxt;
        ox_p1   <= COORD_W'(x_p0 - X_FIRST);
        oy_p1   <= COORD_W'(y_p0 - Y_FIRST);
      end
    end else if (ub.out_ready) begin
      vld_p1 <= 1'b0;
      fd_p1  <= 1'b0;
    end
  end

  assign ub.out_valid  = vld_p1;
  assign ub.frame_done = fd_p1;
  assign ub.out_taps   = taps_p1;
  assign ub.out_x      = ox_p1;
  assign ub.out_y      = oy_p1;

endmodule

// File: tb/tb_stencil_linebuf_ub.sv
// Directed bench for stencil_linebuf_ub: default 3x3 over 64x64, plus a 5x5 over 16x8 instance.
`timescale 1ns/1ps
module tb_stencil_linebuf_ub;

  localparam int DW    = 16;
  localparam int W     = 64;
  localparam int H     = 64;
  localparam int SW    = 3;
  localparam int SH    = 3;
  localparam int NT    = SW * SH;
  localparam int OW    = W - SW + 1;
  localparam int OH    = H - SH + 1;
  localparam int NOUT  = OW * OH;
  localparam int W2    = 16;
  localparam int H2    = 8;
  localparam int SW2   = 5;
  localparam int SH2   = 5;
  localparam int NT2   = SW2 * SH2;
  localparam int OW2   = W2 - SW2 + 1;
  localparam int NOUT2 = OW2 * (H2 - SH2 + 1);

  typedef struct { int x; int y; logic [NT*DW-1:0]  taps; logic fd; } ent_t;
  typedef struct { int x; int y; logic [NT2*DW-1:0] taps; logic fd; } ent2_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic rst2;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  ent_t  q[$];
  ent2_t q2[$];
  int first_vld, fd_cycles, acc131, stall_seen, stall_bad, timeout, fd2;

  logic [NT*DW-1:0] ramp_first;

  stencil_linebuf_ub_if #(.DATA_W(DW), .SW(SW),  .SH(SH))  bus  ();
  stencil_linebuf_ub_if #(.DATA_W(DW), .SW(SW2), .SH(SH2)) bus2 ();

  stencil_linebuf_ub #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .SW(SW), .SH(SH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ub(bus)
  );

  stencil_linebuf_ub #(.DATA_W(DW), .IMG_W(W2), .IMG_H(H2), .SW(SW2), .SH(SH2)) dut2 (
    .clk(clk), .rst(rst2), .flush(1'b0), .ub(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NT*DW-1:0] exp_taps(input int base, input int ox, input int oy);
    logic [NT*DW-1:0] t;
    t = '0;
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        t[(r*SW+c)*DW +: DW] = 16'(base + (oy + r) * W + ox + c);
    return t;
  endfunction

  function automatic logic [NT2*DW-1:0] exp_taps2(input int ox, input int oy);
    logic [NT2*DW-1:0] t;
    t = '0;
    for (int r = 0; r < SH2; r++)
      for (int c = 0; c < SW2; c++)
        t[(r*SW2+c)*DW +: DW] = 16'((oy + r) * W2 + ox + c);
    return t;
  endfunction

  // Streams npix raster pixels (value base + index within frame) into the default DUT
  // and records every consumed stencil, plus timing and stall observations.
  task automatic run(input int npix, input int base, input bit bubble,
                     input int stall_at, input int stall_len);
    int k = 0, drain = 0, budget = 0, stall_left = 0, sa;
    logic [NT*DW-1:0] held_taps;
    logic [15:0] held_x, held_y;
    bit held_ok = 0;
    ent_t e;
    sa = stall_at;
    q.delete();
    first_vld = -1; fd_cycles = 0; acc131 = -1; stall_seen = 0; stall_bad = 0;
    held_taps = '0; held_x = '0; held_y = '0;
    while ((k < npix || drain < 4) && budget < 4 * npix + 100) begin
      @(posedge clk); #1;
      if (stall_left == 0 && k == sa && stall_len > 0) begin
        stall_left = stall_len;
        sa = -1;
      end
      bus.out_ready = (stall_left == 0);
      bus.in_valid  = (k < npix) && (!bubble || $urandom_range(0, 1) == 1);
      bus.in_data   = 16'(base + k % (W * H));
      @(negedge clk);
      budget++;
      if (k >= npix) drain++;
      if (bus.out_valid && first_vld < 0) first_vld = cyc;
      if (bus.frame_done) fd_cycles++;
      if (stall_left > 0) begin
        if (bus.out_valid) begin
          stall_seen++;
          if (bus.in_ready) stall_bad++;
          if (held_ok && (bus.out_taps !== held_taps || bus.out_x !== held_x || bus.out_y !== held_y))
            stall_bad++;
          held_taps = bus.out_taps; held_x = bus.out_x; held_y = bus.out_y; held_ok = 1;
        end
        stall_left--;
      end else begin
        held_ok = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        e.x = int'(bus.out_x); e.y = int'(bus.out_y); e.taps = bus.out_taps; e.fd = bus.frame_done;
        q.push_back(e);
      end
      if (bus.in_valid && bus.in_ready) begin
        k++;
        if (k == 131) acc131 = cyc;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    timeout = (k < npix) ? 1 : 0;
  endtask

  task automatic run2(input int npix);
    int k = 0, drain = 0, budget = 0;
    ent2_t e;
    q2.delete();
    fd2 = 0;
    while ((k < npix || drain < 4) && budget < 4 * npix + 100) begin
      @(posedge clk); #1;
      bus2.out_ready = 1'b1;
      bus2.in_valid  = (k < npix);
      bus2.in_data   = 16'(k % (W2 * H2));
      @(negedge clk);
      budget++;
      if (k >= npix) drain++;
      if (bus2.frame_done) fd2++;
      if (bus2.out_valid && bus2.out_ready) begin
        e.x = int'(bus2.out_x); e.y = int'(bus2.out_y); e.taps = bus2.out_taps; e.fd = bus2.frame_done;
        q2.push_back(e);
      end
      if (bus2.in_valid && bus2.in_ready) k++;
    end
    bus2.in_valid = 1'b0;
    timeout = (k < npix) ? 1 : 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", bus.frame_done); else passed++;
    checks++; if (bus.out_x !== 16'd0) $display("FAIL reset_out_x got %0d want 0", bus.out_x); else passed++;
    checks++; if (bus.out_y !== 16'd0) $display("FAIL reset_out_y got %0d want 0", bus.out_y); else passed++;
    checks++; if (bus.out_taps !== '0) $display("FAIL reset_out_taps got %h want 0", bus.out_taps); else passed++;
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    checks++; if (bus2.out_valid !== 1'b0) $display("FAIL reset2_out_valid got %b want 0", bus2.out_valid); else passed++;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_ramp;
    int nf = 0;
    run(W * H, 0, 0, -1, 0);
    checks++; if (timeout != 0) $display("FAIL ramp_timeout got %0d want 0", timeout); else passed++;
    checks++; if (q.size() != NOUT) $display("FAIL ramp_count got %0d want %0d", q.size(), NOUT); else passed++;
    checks++; if (first_vld != acc131 + 1) $display("FAIL ramp_latency got cycle %0d want %0d", first_vld, acc131 + 1); else passed++;
    checks++; if (fd_cycles != 1) $display("FAIL ramp_frame_done_cycles got %0d want 1", fd_cycles); else passed++;
    if (q.size() > 0) begin
      checks++; if (q[0].taps !== ramp_first) $display("FAIL ramp_first_taps got %h want %h", q[0].taps, ramp_first); else passed++;
      checks++; if (q[q.size()-1].taps[NT*DW-1 -: DW] !== 16'd4095) $display("FAIL ramp_last_tap got %0d want 4095", q[q.size()-1].taps[NT*DW-1 -: DW]); else passed++;
    end
    for (int i = 0; i < q.size(); i++) begin
      int j, ox, oy;
      j = i % NOUT; ox = j % OW; oy = j / OW;
      checks++;
      if (q[i].x != ox || q[i].y != oy || q[i].taps !== exp_taps(0, ox, oy) || q[i].fd !== (j == NOUT - 1)) begin
        if (nf < 5) $display("FAIL ramp_stencil[%0d] got x=%0d y=%0d fd=%b taps=%h want x=%0d y=%0d fd=%b taps=%h",
                             i, q[i].x, q[i].y, q[i].fd, q[i].taps, ox, oy, (j == NOUT - 1), exp_taps(0, ox, oy));
        nf++;
      end else passed++;
    end
  endtask

  task automatic test_backpressure;
    int nf = 0;
    run(W * H, 0, 0, 10 * W + 20, 5);
    checks++; if (timeout != 0) $display("FAIL bp_timeout got %0d want 0", timeout); else passed++;
    checks++; if (stall_seen != 5) $display("FAIL bp_stall_cycles got %0d want 5", stall_seen); else passed++;
    checks++; if (stall_bad != 0) $display("FAIL bp_stall_hold got %0d violations want 0", stall_bad); else passed++;
    checks++; if (q.size() != NOUT) $display("FAIL bp_count got %0d want %0d", q.size(), NOUT); else passed++;
    for (int i = 0; i < q.size(); i++) begin
      int j, ox, oy;
      j = i % NOUT; ox = j % OW; oy = j / OW;
      checks++;
      if (q[i].x != ox || q[i].y != oy || q[i].taps !== exp_taps(0, ox, oy) || q[i].fd !== (j == NOUT - 1)) begin
        if (nf < 5) $display("FAIL bp_stencil[%0d] got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             i, q[i].x, q[i].y, q[i].taps, ox, oy, exp_taps(0, ox, oy));
        nf++;
      end else passed++;
    end
  endtask

  task automatic test_bubbles;
    int nf = 0;
    run(W * H, 256, 1, -1, 0);
    checks++; if (timeout != 0) $display("FAIL bubble_timeout got %0d want 0", timeout); else passed++;
    checks++; if (q.size() != NOUT) $display("FAIL bubble_count got %0d want %0d", q.size(), NOUT); else passed++;
    for (int i = 0; i < q.size(); i++) begin
      int j, ox, oy;
      j = i % NOUT; ox = j % OW; oy = j / OW;
      checks++;
      if (q[i].x != ox || q[i].y != oy || q[i].taps !== exp_taps(256, ox, oy) || q[i].fd !== (j == NOUT - 1)) begin
        if (nf < 5) $display("FAIL bubble_stencil[%0d] got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             i, q[i].x, q[i].y, q[i].taps, ox, oy, exp_taps(256, ox, oy));
        nf++;
      end else passed++;
    end
  endtask

  task automatic test_flush;
    int nf = 0;
    run(11 * W, 16'h1000, 0, -1, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_taps !== '0) $display("FAIL flush_out_taps got %h want 0", bus.out_taps); else passed++;
    checks++; if (bus.out_x !== 16'd0 || bus.out_y !== 16'd0) $display("FAIL flush_coords got %0d,%0d want 0,0", bus.out_x, bus.out_y); else passed++;
    run(W * H, 16'h2000, 0, -1, 0);
    checks++; if (q.size() != NOUT) $display("FAIL flush_count got %0d want %0d", q.size(), NOUT); else passed++;
    checks++; if (first_vld != acc131 + 1) $display("FAIL flush_first_output got cycle %0d want %0d", first_vld, acc131 + 1); else passed++;
    for (int i = 0; i < q.size(); i++) begin
      int j, ox, oy;
      j = i % NOUT; ox = j % OW; oy = j / OW;
      checks++;
      if (q[i].x != ox || q[i].y != oy || q[i].taps !== exp_taps(16'h2000, ox, oy)) begin
        if (nf < 5) $display("FAIL flush_stencil[%0d] got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             i, q[i].x, q[i].y, q[i].taps, ox, oy, exp_taps(16'h2000, ox, oy));
        nf++;
      end else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int nf = 0;
    run(2 * W * H, 0, 0, -1, 0);
    checks++; if (q.size() != 2 * NOUT) $display("FAIL b2b_count got %0d want %0d", q.size(), 2 * NOUT); else passed++;
    checks++; if (fd_cycles != 2) $display("FAIL b2b_frame_done got %0d want 2", fd_cycles); else passed++;
    if (q.size() > NOUT) begin
      checks++; if (q[NOUT].taps !== ramp_first) $display("FAIL b2b_frame2_first got %h want %h", q[NOUT].taps, ramp_first); else passed++;
    end
    for (int i = 0; i < q.size(); i++) begin
      int j, ox, oy;
      j = i % NOUT; ox = j % OW; oy = j / OW;
      checks++;
      if (q[i].x != ox || q[i].y != oy || q[i].taps !== exp_taps(0, ox, oy) || q[i].fd !== (j == NOUT - 1)) begin
        if (nf < 5) $display("FAIL b2b_stencil[%0d] got x=%0d y=%0d fd=%b want x=%0d y=%0d fd=%b",
                             i, q[i].x, q[i].y, q[i].fd, ox, oy, (j == NOUT - 1));
        nf++;
      end else passed++;
    end
  endtask

  task automatic test_variant;
    int nf = 0;
    run2(50);
    checks++; if (q2.size() != 0) $display("FAIL var_partial_count got %0d want 0", q2.size()); else passed++;
    @(posedge clk); #1 rst2 = 1'b1;
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk);
    checks++; if (bus2.out_valid !== 1'b0 || bus2.out_taps !== '0) $display("FAIL var_reset got valid=%b taps=%h want 0", bus2.out_valid, bus2.out_taps); else passed++;
    run2(W2 * H2);
    checks++; if (timeout != 0) $display("FAIL var_timeout got %0d want 0", timeout); else passed++;
    checks++; if (q2.size() != NOUT2) $display("FAIL var_count got %0d want %0d", q2.size(), NOUT2); else passed++;
    checks++; if (fd2 != 1) $display("FAIL var_frame_done got %0d want 1", fd2); else passed++;
    for (int i = 0; i < q2.size(); i++) begin
      int ox, oy;
      ox = i % OW2; oy = i / OW2;
      checks++;
      if (q2[i].x != ox || q2[i].y != oy || q2[i].taps !== exp_taps2(ox, oy) || q2[i].fd !== (i == NOUT2 - 1)) begin
        if (nf < 5) $display("FAIL var_stencil[%0d] got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             i, q2[i].x, q2[i].y, q2[i].taps, ox, oy, exp_taps2(ox, oy));
        nf++;
      end else passed++;
    end
  endtask

  initial begin
    ramp_first = {16'd130, 16'd129, 16'd128, 16'd66, 16'd65, 16'd64, 16'd2, 16'd1, 16'd0};
    test_reset();
    test_ramp();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_back_to_back();
    test_variant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
